// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: configurable UART transmitter (start, 5..DATA_WIDTH data bits LSB first, optional parity, 1/2 stop bits)
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  txValid,
  output logic                  txReady,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic [3:0]            cfgDataWidth,
  input  logic                  cfgParityEnable,
  input  logic                  cfgParityOdd,
  input  logic                  cfgParityErrorInjection,
  input  logic [1:0]            cfgStopBits,
  input  logic [4:0]            cfgOverSample,
  input  logic [DIV_WIDTH-1:0]  cfgBaudDiv,
  output logic                  tx,
  output logic                  txBusy,
  output logic                  txDone
);
  localparam int WW = $clog2(DATA_WIDTH + 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, div_cnt_q, div_cnt_d;
  logic [4:0]            os_q, os_d, tick_cnt_q, tick_cnt_d;
  logic [WW-1:0]         bit_cnt_q, bit_cnt_d, width_q, width_d, w_cfg;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, mask;
  logic                  par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d, tx_q, tx_d;
  logic                  tick, bit_end, last_data, last_stop;
  always_comb begin
    w_cfg = (cfgDataWidth < 4'd5) ? WW'(5) : (int'(cfgDataWidth) > DATA_WIDTH) ? WW'(DATA_WIDTH) : WW'(cfgDataWidth);
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) mask[i] = i < int'(w_cfg);
  end
  assign tick      = div_cnt_q == div_q - DIV_WIDTH'(1);
  assign bit_end   = tick && tick_cnt_q == os_q - 5'd1;
  assign last_data = bit_cnt_q == width_q - WW'(1);
  assign last_stop = bit_cnt_q == WW'(stop2_q);
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    os_d       = os_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    width_d    = width_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    if (state_q != IDLE) begin
      div_cnt_d  = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
      tick_cnt_d = bit_end ? '0 : tick ? tick_cnt_q + 5'd1 : tick_cnt_q;
    end
    case (state_q)
      IDLE: if (txValid) begin
        state_d   = START;
        div_d     = (cfgBaudDiv == '0) ? DIV_WIDTH'(1) : cfgBaudDiv;
        os_d      = (cfgOverSample == 5'd13) ? 5'd13 : 5'd16;
        width_d   = w_cfg;
        shift_d   = txData & mask;
        par_en_d  = cfgParityEnable;
        par_d     = ^(txData & mask) ^ cfgParityOdd ^ cfgParityErrorInjection;
        stop2_d   = cfgStopBits == 2'd2;
        bit_cnt_d = '0;
      end
      START:  if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = last_data ? '0 : bit_cnt_q + WW'(1);
        if (last_data) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        bit_cnt_d = last_stop ? '0 : bit_cnt_q + WW'(1);
        if (last_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // line level follows the next state so tx changes on the same edge as the FSM
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= DIV_WIDTH'(1);
      div_cnt_q  <= '0;
      os_q       <= 5'd16;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      width_q    <= WW'(DATA_WIDTH);
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      os_q       <= os_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      width_q    <= width_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end
  assign tx      = tx_q;
  assign txReady = state_q == IDLE;
  assign txBusy  = state_q != IDLE;
  assign txDone  = state_q == STOP && bit_end && last_stop;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench; expected frames are queued at acceptance and checked bit by bit on tx
module tb_uart_tx_serializer;
  typedef struct {
    logic [15:0] bits;
    int          n;
    int          t;
  } frame_t;
  logic        clk = 1'b0, rst_n = 1'b0, txValid = 1'b0;
  logic        txReady, tx, txBusy, txDone;
  logic [7:0]  txData = '0;
  logic [3:0]  cfgDataWidth = 4'd8;
  logic        cfgParityEnable = 1'b0, cfgParityOdd = 1'b0, cfgParityErrorInjection = 1'b0;
  logic [1:0]  cfgStopBits = 2'd1;
  logic [4:0]  cfgOverSample = 5'd16;
  logic [15:0] cfgBaudDiv = 16'd1;
  frame_t      sb[$];
  int          errs = 0, checks = 0, cyc = 0, acc_cyc = 0, pushed = 0, done_cnt = 0, a0 = 0, snap = 0;
  bit          mon_off = 1'b0;
  uart_tx_serializer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .txValid(txValid), .txReady(txReady), .txData(txData),
    .cfgDataWidth(cfgDataWidth), .cfgParityEnable(cfgParityEnable), .cfgParityOdd(cfgParityOdd),
    .cfgParityErrorInjection(cfgParityErrorInjection), .cfgStopBits(cfgStopBits),
    .cfgOverSample(cfgOverSample), .cfgBaudDiv(cfgBaudDiv), .tx(tx), .txBusy(txBusy), .txDone(txDone)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && txDone) done_cnt <= done_cnt + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input int w, input bit pe, input bit po, input bit inj,
                      input int stops, input int os, input int div);
    frame_t e;
    int     we, waited;
    bit     p;
    @(negedge clk);
    txData = d; cfgDataWidth = 4'(w); cfgParityEnable = pe; cfgParityOdd = po;
    cfgParityErrorInjection = inj; cfgStopBits = 2'(stops); cfgOverSample = 5'(os); cfgBaudDiv = 16'(div);
    txValid = 1'b1;
    waited = 0;
    while (!txReady && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!txReady) begin
      check("accept_timeout", 32'd0, 32'd1);
      txValid = 1'b0;
      return;
    end
    we = (w < 5) ? 5 : (w > 8) ? 8 : w;
    e.bits = '0; e.n = 0; p = 1'b0;
    e.t = ((os == 13) ? 13 : 16) * ((div == 0) ? 1 : div);
    e.bits[e.n++] = 1'b0;
    for (int i = 0; i < we; i++) begin
      e.bits[e.n++] = d[i];
      p ^= d[i];
    end
    if (pe) e.bits[e.n++] = p ^ po ^ inj;
    for (int i = 0; i < ((stops == 2) ? 2 : 1); i++) e.bits[e.n++] = 1'b1;
    if (!mon_off) begin
      sb.push_back(e);
      pushed++;
    end
    @(posedge clk);
    #1 acc_cyc = cyc;
  endtask
  task automatic drain();
    int waited = 0;
    @(negedge clk);
    txValid = 1'b0;
    while ((sb.size() != 0 || txBusy) && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 6000) check("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask
  initial begin : monitor
    frame_t e;
    logic   prev = 1'b1, obs, early;
    forever begin
      @(negedge clk);
      if (!mon_off && rst_n && tx === 1'b0 && prev === 1'b1) begin
        if (sb.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          early = 1'b0;
          for (int k = 0; k < e.n; k++) begin
            obs = e.bits[k];
            for (int c = 0; c < e.t; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (tx !== e.bits[k]) obs = tx;
              if (txDone && !(k == e.n - 1 && c == e.t - 1)) early = 1'b1;
            end
            check($sformatf("bit%0d", k), 32'(obs), 32'(e.bits[k]));
          end
          check("early_done", 32'(early), 32'd0);
          check("done_last_clk", 32'(txDone), 32'd1);
          @(negedge clk);
          check("idle_gap", 32'({tx, txBusy, txReady}), 32'b101);
        end
      end
      prev = tx;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", 32'({tx, txReady, txBusy, txDone}), 32'b1100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hA5, 8, 1, 0, 0, 1, 16, 1);
    check("latency_tx", 32'({tx, txBusy, txReady}), 32'b010);
    drain();
    send(8'hFF, 5, 1, 1, 0, 2, 13, 2);
    drain();
    send(8'hA5, 8, 1, 0, 1, 1, 16, 1);
    drain();
    send(8'h3C, 8, 1, 0, 0, 1, 16, 1);
    a0 = acc_cyc;
    send(8'hC3, 8, 1, 0, 0, 1, 16, 1);
    check("b2b_spacing1", 32'(acc_cyc - a0), 32'd177);
    a0 = acc_cyc;
    send(8'h5A, 8, 1, 0, 0, 1, 16, 1);
    check("b2b_spacing2", 32'(acc_cyc - a0), 32'd177);
    drain();
    send(8'h96, 8, 0, 0, 0, 1, 16, 1);
    a0 = acc_cyc;
    send(8'h1B, 5, 1, 1, 0, 2, 13, 1);
    check("cfg_change_spacing", 32'(acc_cyc - a0), 32'd161);
    drain();
    send(8'hE7, 3, 1, 0, 0, 2, 10, 0);
    drain();
    send(8'h81, 12, 0, 0, 0, 3, 13, 3);
    drain();
    mon_off = 1'b1;
    send(8'h3C, 8, 1, 0, 0, 1, 16, 1);
    txValid = 1'b0;
    repeat (16 + 48 + 5) @(posedge clk);
    snap = done_cnt;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({tx, txBusy, txReady}), 32'b101);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_on_abort", 32'(done_cnt), 32'(snap));
    check("ready_after_reset", 32'({tx, txReady}), 32'b11);
    mon_off = 1'b0;
    send(8'h6D, 7, 1, 1, 0, 1, 16, 2);
    drain();
    check("done_count", 32'(done_cnt), 32'(pushed));
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
